// File: rtl/spi_bus_arbiter.sv
// Two-master SPI flash arbiter: shares one flash between requester A (USB bridge) and B (flash reader).
// Optional hold-timeout watchdog is compiled only with SPI_BUS_ARBITER_TIMEOUT_EN defined.
module spi_bus_arbiter #(
    parameter int unsigned TURNAROUND     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic a_req,
    output logic a_gnt,
    input  logic a_cs_b,
    input  logic a_sck,
    input  logic a_mosi,
    output logic a_miso,
    input  logic b_req,
    output logic b_gnt,
    input  logic b_cs_b,
    input  logic b_sck,
    input  logic b_mosi,
    output logic b_miso,
    output logic spi_cs_b,
    output logic spi_sck,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic busy,
    output logic owner,
    output logic timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2,
        ST_PARK    = 2'd3
    } state_t;

    // PARK lasts TURNAROUND cycles, so the down-counter is loaded with one less.
    localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

    state_t     r_state;
    logic       r_a_gnt;
    logic       r_b_gnt;
    logic       r_busy;
    logic       r_owner;
    logic       r_last_b;
    logic [3:0] r_park_cnt;
    logic       w_a_release;
    logic       w_b_release;
    logic       w_to_hit;

    assign w_a_release = !a_req && a_cs_b;
    assign w_b_release = !b_req && b_cs_b;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_timeout_pulse;
    logic        w_contended;

    assign w_contended = ((r_state == ST_GRANT_A) && b_req) ||
                         ((r_state == ST_GRANT_B) && a_req);
    assign w_to_hit    = w_contended && (r_to_cnt == TO_LAST);

    // Contended-hold counter and the registered revoke pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt        <= 16'd0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_to_hit;
            if (w_contended && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end else begin
                r_to_cnt <= 16'd0;
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_to_hit      = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Arbitration FSM with registered grant, busy and owner outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_a_gnt    <= 1'b0;
            r_b_gnt    <= 1'b0;
            r_busy     <= 1'b0;
            r_owner    <= 1'b0;
            r_last_b   <= 1'b1;
            r_park_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (a_req && (!b_req || r_last_b)) begin
                        r_state  <= ST_GRANT_A;
                        r_a_gnt  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_owner  <= 1'b0;
                        r_last_b <= 1'b0;
                    end else if (b_req) begin
                        r_state  <= ST_GRANT_B;
                        r_b_gnt  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_owner  <= 1'b1;
                        r_last_b <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_GRANT_A: begin
                    if (w_a_release || w_to_hit) begin
                        r_state    <= ST_PARK;
                        r_a_gnt    <= 1'b0;
                        r_park_cnt <= TURN_LOAD;
                        r_last_b   <= 1'b0;
                    end else begin
                        r_state    <= ST_GRANT_A;
                    end
                end
                ST_GRANT_B: begin
                    if (w_b_release || w_to_hit) begin
                        r_state    <= ST_PARK;
                        r_b_gnt    <= 1'b0;
                        r_park_cnt <= TURN_LOAD;
                        r_last_b   <= 1'b1;
                    end else begin
                        r_state    <= ST_GRANT_B;
                    end
                end
                ST_PARK: begin
                    // Requests are deliberately ignored here; arbitration resumes in IDLE.
                    if (r_park_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_park_cnt <= r_park_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_a_gnt    <= 1'b0;
                    r_b_gnt    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_park_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Pin routing follows the registered grant so reset parks the bus without a clock.
    always_comb begin
        spi_cs_b = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        a_miso   = 1'b0;
        b_miso   = 1'b0;
        if (r_a_gnt) begin
            spi_cs_b = a_cs_b;
            spi_sck  = a_sck;
            spi_mosi = a_mosi;
            a_miso   = spi_miso;
        end else if (r_b_gnt) begin
            spi_cs_b = b_cs_b;
            spi_sck  = b_sck;
            spi_mosi = b_mosi;
            b_miso   = spi_miso;
        end else begin
            spi_cs_b = 1'b1;
            spi_sck  = 1'b0;
            spi_mosi = 1'b0;
        end
    end

    assign a_gnt = r_a_gnt;
    assign b_gnt = r_b_gnt;
    assign busy  = r_busy;
    assign owner = r_owner;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed table, hand sequences and random traffic vs. an owner/park model.
module tb_spi_bus_arbiter;

    localparam int TURN = 2;
    localparam int TO   = 16;

    logic clk, reset;
    logic a_req, a_gnt, a_cs_b, a_sck, a_mosi, a_miso;
    logic b_req, b_gnt, b_cs_b, b_sck, b_mosi, b_miso;
    logic spi_cs_b, spi_sck, spi_mosi, spi_miso;
    logic busy, owner, timeout_pulse;

    int n_vec = 0;
    int n_err = 0;

    // model: who holds the bus (-1 none), parking cycles left, last served, contended count
    int m_owner, m_park, m_last, m_ctd;
    logic m_pulse;

    spi_bus_arbiter #(.TURNAROUND(TURN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_gnt(a_gnt), .a_cs_b(a_cs_b), .a_sck(a_sck), .a_mosi(a_mosi), .a_miso(a_miso),
        .b_req(b_req), .b_gnt(b_gnt), .b_cs_b(b_cs_b), .b_sck(b_sck), .b_mosi(b_mosi), .b_miso(b_miso),
        .spi_cs_b(spi_cs_b), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .busy(busy), .owner(owner), .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a_req, b_req, a_cs_b, b_cs_b;
        logic e_a_gnt, e_b_gnt, e_busy, e_owner, e_cs_b;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ar, br, acs, bcs, ag, bg, bz, ow, cs);
        vec_t v;
        v.a_req = ar; v.b_req = br; v.a_cs_b = acs; v.b_cs_b = bcs;
        v.e_a_gnt = ag; v.e_b_gnt = bg; v.e_busy = bz; v.e_owner = ow; v.e_cs_b = cs;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_park = 0; m_last = 1; m_ctd = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic rel;
        m_pulse = 1'b0;
        if (m_owner >= 0) begin
            rel = (m_owner == 0) ? (!a_req && a_cs_b) : (!b_req && b_cs_b);
            if (rel) begin
                m_owner = -1; m_park = TURN; m_ctd = 0;
            end else begin
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
                if ((m_owner == 0) ? b_req : a_req) begin
                    m_ctd++;
                    if (m_ctd == TO) begin
                        m_pulse = 1'b1; m_last = m_owner; m_owner = -1; m_park = TURN; m_ctd = 0;
                    end
                end else begin
                    m_ctd = 0;
                end
`endif
            end
        end else if (m_park > 0) begin
            m_park--;
        end else begin
            if (a_req && b_req) m_owner = 1 - m_last;
            else if (a_req)     m_owner = 0;
            else if (b_req)     m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
        end
    endtask

    task automatic model_check();
        logic ecs, esck, emosi;
        ecs   = (m_owner == 0) ? a_cs_b : (m_owner == 1) ? b_cs_b : 1'b1;
        esck  = (m_owner == 0) ? a_sck  : (m_owner == 1) ? b_sck  : 1'b0;
        emosi = (m_owner == 0) ? a_mosi : (m_owner == 1) ? b_mosi : 1'b0;
        chk("a_gnt", a_gnt, m_owner == 0);
        chk("b_gnt", b_gnt, m_owner == 1);
        chk("gnt_excl", a_gnt && b_gnt, 1'b0);
        chk("busy", busy, (m_owner >= 0) || (m_park > 0));
        if (m_owner >= 0) chk("owner", owner, m_owner == 1);
        chk("spi_cs_b", spi_cs_b, ecs);
        chk("spi_sck", spi_sck, esck);
        chk("spi_mosi", spi_mosi, emosi);
        chk("a_miso", a_miso, (m_owner == 0) && spi_miso);
        chk("b_miso", b_miso, (m_owner == 1) && spi_miso);
        chk("timeout_pulse", timeout_pulse, m_pulse);
    endtask

    // one clock: drive at negedge, check just after, advance model at posedge
    task automatic cycle(input logic ar, br, acs, bcs);
        @(negedge clk);
        a_req = ar; b_req = br; a_cs_b = acs; b_cs_b = bcs;
        a_sck = 1'($urandom); a_mosi = 1'($urandom);
        b_sck = 1'($urandom); b_mosi = 1'($urandom);
        spi_miso = 1'($urandom);
        #1 model_check();
        @(posedge clk);
        model_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_gnt"}, a_gnt, 1'b0);
        chk({tag, "_b_gnt"}, b_gnt, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_owner"}, owner, 1'b0);
        chk({tag, "_timeout"}, timeout_pulse, 1'b0);
        chk({tag, "_spi_cs_b"}, spi_cs_b, 1'b1);
        chk({tag, "_spi_sck"}, spi_sck, 1'b0);
        chk({tag, "_spi_mosi"}, spi_mosi, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0; a_cs_b = 1'b1; b_cs_b = 1'b1;
        reset = 1'b0;
        model_reset();
        #1 check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_cs_b = 1'b1; b_cs_b = 1'b1;
        a_sck = 1'b1; a_mosi = 1'b0; b_sck = 1'b0; b_mosi = 1'b1; spi_miso = 1'b1;
        model_reset();
        #2 check_reset_outputs("por");

        //            a  b  acs bcs | ag bg busy own cs
        tbl[0]  = mk(1, 1, 1, 1,   0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 1, 0, 1,   1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1,   1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 1, 1,   1, 0, 1, 0, 1);
        tbl[4]  = mk(1, 1, 1, 1,   0, 0, 1, 0, 1);
        tbl[5]  = mk(1, 1, 1, 1,   0, 0, 1, 0, 1);
        tbl[6]  = mk(1, 1, 1, 1,   0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 1, 0,   0, 1, 1, 1, 0);
        tbl[8]  = mk(1, 0, 1, 1,   0, 1, 1, 1, 1);
        tbl[9]  = mk(1, 1, 1, 1,   0, 0, 1, 0, 1);
        tbl[10] = mk(1, 1, 1, 1,   0, 0, 1, 0, 1);
        tbl[11] = mk(1, 1, 1, 1,   0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 1, 1,   1, 0, 1, 0, 1);
        tbl[13] = mk(0, 0, 1, 1,   0, 0, 1, 0, 1);
        tbl[14] = mk(0, 0, 1, 1,   0, 0, 1, 0, 1);
        tbl[15] = mk(0, 0, 1, 1,   0, 0, 0, 0, 1);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        // Directed table: tie after reset, CS hold, parking, alternation, re-request in PARK.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_req = tbl[i].a_req; b_req = tbl[i].b_req;
            a_cs_b = tbl[i].a_cs_b; b_cs_b = tbl[i].b_cs_b;
            #1;
            chk($sformatf("tbl%0d_a_gnt", i), a_gnt, tbl[i].e_a_gnt);
            chk($sformatf("tbl%0d_b_gnt", i), b_gnt, tbl[i].e_b_gnt);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_a_gnt || tbl[i].e_b_gnt)
                chk($sformatf("tbl%0d_owner", i), owner, tbl[i].e_owner);
            chk($sformatf("tbl%0d_spi_cs_b", i), spi_cs_b, tbl[i].e_cs_b);
            chk($sformatf("tbl%0d_spi_sck", i), spi_sck, tbl[i].e_a_gnt);
            chk($sformatf("tbl%0d_spi_mosi", i), spi_mosi, tbl[i].e_b_gnt);
            chk($sformatf("tbl%0d_a_miso", i), a_miso, tbl[i].e_a_gnt);
            chk($sformatf("tbl%0d_b_miso", i), b_miso, tbl[i].e_b_gnt);
            @(posedge clk);
        end

        // Hold on CS: A drops req mid-transfer and keeps CS low for 5 cycles.
        do_reset();
        cycle(1, 0, 1, 1);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1);
        cycle(0, 1, 1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 1);
        cycle(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);

        // Long contended hold: revoked after TO cycles with the watchdog, held otherwise.
        do_reset();
        cycle(1, 0, 0, 1);
        for (int i = 0; i < TO + 8; i++) cycle(1, 1, 0, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);

        // Reset mid-transfer while B owns the bus: parking must not need a clock edge.
        do_reset();
        cycle(0, 1, 1, 1);
        cycle(0, 1, 1, 0);
        @(negedge clk);
        #1 chk("pre_rst_b_gnt", b_gnt, 1'b1);
        chk("pre_rst_spi_cs_b", spi_cs_b, 1'b0);
        #1 reset = 1'b0;
        #1 chk("async_b_gnt", b_gnt, 1'b0);
        chk("async_spi_cs_b", spi_cs_b, 1'b1);
        chk("async_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1; b_cs_b = 1'b1; a_cs_b = 1'b1;
        model_reset();
        @(posedge clk);
        model_step();
        cycle(1, 1, 1, 1);
        chk("post_rst_tie_model_a", m_owner == 0 || m_park > 0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);

        // Random traffic with sticky requests and chip selects.
        begin
            logic ar, br, acs, bcs;
            ar = 1'b0; br = 1'b0; acs = 1'b1; bcs = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 4) == 0) ar = ~ar;
                if ($urandom_range(0, 4) == 0) br = ~br;
                if ($urandom_range(0, 3) == 0) acs = ~acs;
                if ($urandom_range(0, 3) == 0) bcs = ~bcs;
                cycle(ar, br, acs, bcs);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter TURNAROUND, default 2: idle cycles with bus parked between owners (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum contended hold, 16-bit.
REQ-003 SHALL have ports clk input 1, the single clock; reset input 1, asynchronous, active-low (low = in reset).
REQ-004 SHALL have ports a_req input 1 and a_gnt output 1: requester A, the USB SPI bridge.
REQ-005 SHALL have ports a_cs_b, a_sck, a_mosi (input 1 each) and a_miso (output 1): requester A pins.
REQ-006 SHALL have ports b_req input 1 and b_gnt output 1: requester B, the user-side flash reader.
REQ-007 SHALL have ports b_cs_b, b_sck, b_mosi (input 1 each) and b_miso (output 1): requester B pins.
REQ-008 SHALL have ports spi_cs_b, spi_sck, spi_mosi (output 1 each) and spi_miso (input 1): flash pins.
REQ-009 SHALL have ports busy output 1 (state != IDLE) and owner output 1 (0 = A, 1 = B, valid while a grant is active).
REQ-010 SHALL have port timeout_pulse output 1: one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 SHALL implement states IDLE, GRANT_A, GRANT_B, and PARK; the state SHALL be registered.
REQ-012 SHALL, in IDLE with exactly one req high, enter that requester's GRANT state; gnt SHALL be high the cycle after the req is sampled.
REQ-013 SHALL, in IDLE with both reqs high, grant the requester not served last; the last-served flop SHALL reset to B, so A wins the first tie.
REQ-014 SHALL, in GRANT_x, drive spi_cs_b/spi_sck/spi_mosi combinationally from x's pins and route spi_miso to x_miso; the other x_miso SHALL be 0.
REQ-015 SHALL hold the grant while x_req is high OR x_cs_b is low; the arbiter never releases mid-transaction.
REQ-016 SHALL go from GRANT_x to PARK in the cycle where x_req is low and x_cs_b is high; x_gnt SHALL drop on entry to PARK.
REQ-017 SHALL, outside GRANT states, drive spi_cs_b=1, spi_sck=0, spi_mosi=0.
REQ-018 SHALL stay in PARK exactly TURNAROUND cycles (4-bit down-counter), then go to IDLE; reqs are ignored during PARK.
REQ-019 SHALL keep a_gnt and b_gnt mutually exclusive in every cycle.
REQ-020 SHALL, when a requester deasserts req and re-asserts it in PARK, arbitrate that requester in IDLE normally after PARK (no shortcut).

Reset
REQ-021 SHALL, on reset low, immediately (asynchronously) force state=IDLE, a_gnt=b_gnt=0, busy=0, owner=0, timeout_pulse=0, last-served=B, counters=0, and park the bus pins (REQ-017).
REQ-022 SHALL, when reset asserts mid-transaction, abandon the transaction; after release, the first arbitration SHALL follow REQ-012/013.

Configuration
REQ-023 SHALL compile a hold-timeout watchdog only when macro SPI_BUS_ARBITER_TIMEOUT_EN is defined.
REQ-024 SHALL, with SPI_BUS_ARBITER_TIMEOUT_EN defined, count cycles in GRANT_x while the other req is high (count cleared otherwise).
REQ-025 SHALL, in that mode, when the count reaches TIMEOUT_CYCLES, pulse timeout_pulse, enter PARK regardless of x_cs_b, and set last-served to x.
REQ-026 SHALL, without SPI_BUS_ARBITER_TIMEOUT_EN, have no counter and tie timeout_pulse to 0; grants are held indefinitely per REQ-015.

Verification
REQ-027 Single A: a_req=1 at cycle 0 -> a_gnt=1 at cycle 1, spi pins follow A; a_req=0, a_cs_b=1 at cycle 10 -> a_gnt=0 at cycle 11, IDLE at cycle 13 (TURNAROUND=2).
REQ-028 Tie after reset: a_req=b_req=1 -> A granted; A releases -> B granted 1 cycle after PARK ends; then a tie again -> A granted.
REQ-029 Hold on CS: a_req drops while a_cs_b=0 for 5 more cycles -> a_gnt stays 1 until the cycle after a_cs_b=1; spi_cs_b never glitches high.
REQ-030 Parking: during PARK with b_req=1 -> spi_cs_b=1, spi_sck=0, b_gnt=0 for exactly 2 cycles; b_miso=0 while B is not granted.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=16): A holds with b_req=1 -> timeout_pulse at the 16th contended cycle, a_gnt=0, B granted after PARK.
REQ-032 Reset mid-transfer: reset=0 while GRANT_B with b_cs_b=0 -> b_gnt=0 and spi_cs_b=1 without a clock edge.
